// File: rtl/img_frame_loader_if.sv
// Raster-order pixel stream handshake from the upstream deserialiser into the frame loader.
interface img_frame_loader_if #(
    parameter int unsigned PIX_W = 8
) ();
    logic             s_valid;
    logic [PIX_W-1:0] s_data;
    logic             s_last;
    logic             s_ready;

    modport master (output s_valid, s_data, s_last, input  s_ready);
    modport slave  (input  s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/img_frame_loader.sv
// Writer side of the pooling input buffer: fills a raster frame from a pixel stream,
// then holds it stable for the consumer until it is acknowledged.
module img_frame_loader #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    img_frame_loader_if.slave    pix,
    output logic [PIX_W-1:0]     img [0:IMG_W*IMG_H-1],
    output logic                 frame_valid,
    input  logic                 frame_ack,
    output logic [4:0]           wr_row,
    output logic [4:0]           wr_col,
    output logic                 err_short,
    output logic                 err_long,
    output logic [7:0]           frame_count
);
    localparam int unsigned N_PIX = IMG_W * IMG_H;
    localparam int unsigned IDX_W = $clog2(N_PIX);
    localparam int unsigned POS_W = 5;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {FILL, FULL} state_t;

    state_t             state_q, state_d;
    logic               s_ready_q;
    logic [POS_W-1:0]   row_d, col_d;
    logic [CNT_W-1:0]   count_d;
    logic               err_short_d, err_long_d;
    logic               xfer;
    logic               last_pix;
    logic [IDX_W-1:0]   wr_idx;

    assign pix.s_ready = s_ready_q;
    assign xfer        = pix.s_valid && s_ready_q;
    assign last_pix    = (wr_row == POS_W'(IMG_H - 1)) && (wr_col == POS_W'(IMG_W - 1));
    assign wr_idx      = IDX_W'(wr_row) * IDX_W'(IMG_W) + IDX_W'(wr_col);

    // Next-state, raster position, frame counter and error pulses.
    always_comb begin
        state_d     = state_q;
        row_d       = wr_row;
        col_d       = wr_col;
        count_d     = frame_count;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        case (state_q)
            FILL: begin
                if (xfer) begin
                    if (last_pix) begin
                        row_d      = '0;
                        col_d      = '0;
                        state_d    = FULL;
                        count_d    = frame_count + CNT_W'(1);
                        err_long_d = !pix.s_last;
                    end else if (pix.s_last) begin
                        row_d       = '0;
                        col_d       = '0;
                        err_short_d = 1'b1;
                    end else if (wr_col == POS_W'(IMG_W - 1)) begin
                        col_d = '0;
                        row_d = wr_row + POS_W'(1);
                    end else begin
                        col_d = wr_col + POS_W'(1);
                    end
                end
            end
            FULL: begin
                if (frame_ack) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // Handshake/status outputs are registered from the next state so they track it without input paths.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            s_ready_q   <= 1'b1;
            frame_valid <= 1'b0;
            wr_row      <= '0;
            wr_col      <= '0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q     <= state_d;
            s_ready_q   <= (state_d == FILL);
            frame_valid <= (state_d == FULL);
            wr_row      <= row_d;
            wr_col      <= col_d;
            err_short   <= err_short_d;
            err_long    <= err_long_d;
            frame_count <= count_d;
        end
    end

    // Frame storage is not reset; it is only written on accepted transfers.
    always_ff @(posedge clk) begin
        if (xfer) img[wr_idx] <= pix.s_data;
    end
endmodule

// File: tb/tb_img_frame_loader.sv
// Self-checking bench for img_frame_loader: scenario table plus hand-written FULL-hold and reset sequences.
module tb_img_frame_loader;
    localparam int unsigned IMG_W = 28;
    localparam int unsigned IMG_H = 28;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned N_PIX = IMG_W * IMG_H;

    logic             clk;
    logic             reset;
    logic             frame_ack;
    logic             frame_valid;
    logic             err_short;
    logic             err_long;
    logic [4:0]       wr_row;
    logic [4:0]       wr_col;
    logic [7:0]       frame_count;
    logic [PIX_W-1:0] img [0:N_PIX-1];

    img_frame_loader_if #(.PIX_W(PIX_W)) pix ();

    img_frame_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .pix         (pix),
        .img         (img),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .err_short   (err_short),
        .err_long    (err_long),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int n_pix;
        int last_at;
        int gap_pct;
        bit rand_data;
        bit ack_hold;
        int hold;
        bit exp_full;
        int exp_es;
        int exp_el;
        int exp_dcount;
    } scen_t;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: linear pixel position within the frame plus a full flag.
    int         m_pos;
    bit         m_full;
    int         m_count;
    bit         m_es;
    bit         m_el;
    logic [7:0] m_img [0:N_PIX-1];
    int         es_seen;
    int         el_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic int img_mismatch();
        int n = 0;
        for (int i = 0; i < int'(N_PIX); i++) if (img[i] !== m_img[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_full = 0; m_count = 0; m_es = 0; m_el = 0;
    endtask

    task automatic check_all();
        chk("wr_row",      32'(wr_row),      32'(m_pos / int'(IMG_W)));
        chk("wr_col",      32'(wr_col),      32'(m_pos % int'(IMG_W)));
        chk("frame_valid", 32'(frame_valid), 32'(m_full));
        chk("s_ready",     32'(pix.s_ready), 32'(!m_full));
        chk("err_short",   32'(err_short),   32'(m_es));
        chk("err_long",    32'(err_long),    32'(m_el));
        chk("frame_count", 32'(frame_count), 32'(m_count));
    endtask

    // One clock cycle of stimulus; model advances on the same edge, then outputs are compared.
    task automatic cycle(input bit valid, input logic [7:0] data, input bit last, input bit ack);
        pix.s_valid = valid;
        pix.s_data  = data;
        pix.s_last  = last;
        frame_ack   = ack;
        @(posedge clk);
        #1;
        m_es = 0;
        m_el = 0;
        if (!m_full) begin
            if (valid) begin
                m_img[m_pos] = data;
                if (m_pos == int'(N_PIX) - 1) begin
                    m_full  = 1;
                    m_count = (m_count + 1) % 256;
                    m_el    = !last;
                    m_pos   = 0;
                end else if (last) begin
                    m_es  = 1;
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
        end else if (ack) begin
            m_full = 0;
        end
        es_seen += int'(err_short);
        el_seen += int'(err_long);
        check_all();
    endtask

    task automatic run_scen(input scen_t s);
        int         base;
        logic [7:0] d;
        base    = m_count;
        es_seen = 0;
        el_seen = 0;
        for (int i = 0; i < s.n_pix; i++) begin
            while (int'($urandom_range(99)) < s.gap_pct) cycle(1'b0, 8'($urandom), 1'b0, s.ack_hold);
            d = s.rand_data ? 8'($urandom) : 8'(i % 256);
            cycle(1'b1, d, i == s.last_at, s.ack_hold);
        end
        pix.s_valid = 1'b0;
        frame_ack   = 1'b0;
        chk("scen_frame_valid", 32'(frame_valid), 32'(s.exp_full));
        chk("scen_frame_count", 32'(frame_count), 32'((base + s.exp_dcount) % 256));
        chk("scen_err_short_pulses", 32'(es_seen), 32'(s.exp_es));
        chk("scen_err_long_pulses",  32'(el_seen), 32'(s.exp_el));
        if (s.exp_full) begin
            chk("scen_img", 32'(img_mismatch()), 32'd0);
            if (!s.rand_data) begin
                chk("img0",   32'(img[0]),   32'd0);
                chk("img27",  32'(img[27]),  32'd27);
                chk("img28",  32'(img[28]),  32'd28);
                chk("img783", 32'(img[783]), 32'd15);
            end
            // Upstream keeps pushing while the frame is held; nothing may be written.
            for (int j = 0; j < s.hold; j++) cycle(1'b1, 8'hAA, 1'b0, 1'b0);
            chk("hold_img", 32'(img_mismatch()), 32'd0);
            // Ack held for three cycles must release exactly once.
            for (int j = 0; j < 3; j++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
            chk("ack_s_ready",     32'(pix.s_ready), 32'd1);
            chk("ack_frame_valid", 32'(frame_valid), 32'd0);
            chk("ack_wr_row",      32'(wr_row),      32'd0);
            chk("ack_wr_col",      32'(wr_col),      32'd0);
        end
    endtask

    scen_t tbl [4];

    initial begin
        tbl[0] = '{n_pix: 784, last_at: 783, gap_pct: 0,  rand_data: 0, ack_hold: 0, hold: 50,
                   exp_full: 1, exp_es: 0, exp_el: 0, exp_dcount: 1};
        tbl[1] = '{n_pix: 101, last_at: 100, gap_pct: 0,  rand_data: 1, ack_hold: 1, hold: 0,
                   exp_full: 0, exp_es: 1, exp_el: 0, exp_dcount: 0};
        tbl[2] = '{n_pix: 784, last_at: -1,  gap_pct: 0,  rand_data: 1, ack_hold: 0, hold: 5,
                   exp_full: 1, exp_es: 0, exp_el: 1, exp_dcount: 1};
        tbl[3] = '{n_pix: 784, last_at: 783, gap_pct: 30, rand_data: 0, ack_hold: 0, hold: 5,
                   exp_full: 1, exp_es: 0, exp_el: 0, exp_dcount: 1};

        reset       = 1'b0;
        pix.s_valid = 1'b0;
        pix.s_data  = '0;
        pix.s_last  = 1'b0;
        frame_ack   = 1'b0;
        es_seen     = 0;
        el_seen     = 0;
        model_reset();
        #12;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int k = 0; k < 4; k++) run_scen(tbl[k]);

        // Asynchronous reset in the middle of a frame abandons it immediately.
        for (int i = 0; i < 400; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        pix.s_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_s_ready",     32'(pix.s_ready), 32'd1);
        chk("rst_wr_row",      32'(wr_row),      32'd0);
        chk("rst_wr_col",      32'(wr_col),      32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_scen(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/img_frame_loader.md
Name: img_frame_loader

Overview:
- Writer side of the 28x28 image buffer that the average pooling layer reads.
- Accepts a raster-order pixel stream over a valid/ready handshake and writes each pixel into a frame buffer, counting rows and columns.
- Presents the completed frame to the pooling layer and holds it stable until the consumer acknowledges it.
- Sits between the input interface (UART/camera deserialiser) and avg_pooling_layer.

Parameters:
- IMG_W, 28, pixels per row
- IMG_H, 28, rows per frame
- PIX_W, 8, bits per pixel
- N_PIX, IMG_W*IMG_H (784), derived; pixels per frame

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- s_valid  in  1  input pixel valid
- s_data  in  PIX_W  input pixel value, unsigned
- s_last  in  1  marks the final pixel of a frame; qualified by s_valid
- s_ready  out  1  loader can accept a pixel
- img  out  PIX_W x N_PIX  frame buffer, unpacked array [0:N_PIX-1], index = row*IMG_W+col
- frame_valid  out  1  img holds a complete frame (starts pooling)
- frame_ack  in  1  consumer finished with img; releases the buffer
- wr_row  out  5  current write row, 0..IMG_H-1
- wr_col  out  5  current write column, 0..IMG_W-1
- err_short  out  1  one-cycle pulse: s_last arrived before pixel N_PIX
- err_long  out  1  one-cycle pulse: pixel N_PIX accepted without s_last
- frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- Handshake: a pixel transfers on a rising clk edge where s_valid=1 and s_ready=1. s_data and s_last are sampled only on a transfer.
- Reset (reset=0, asynchronous) drives:
  - state=FILL, s_ready=1
  - frame_valid=0, wr_row=0, wr_col=0
  - err_short=0, err_long=0, frame_count=0
- img contents are not cleared by reset and are undefined until the first write.
- State FILL:
  - s_ready=1, frame_valid=0.
  - Each transfer writes s_data to img[wr_row*IMG_W+wr_col] at that edge.
  - After the write, wr_col increments. At IMG_W-1 it wraps to 0 and wr_row increments.
- Early s_last: a transfer with s_last=1 before the N_PIX-th pixel stores the pixel, then:
  - err_short pulses for the next cycle
  - wr_row and wr_col return to 0; the frame is discarded
  - frame_count is unchanged and the state stays FILL.
- Transfer of the N_PIX-th pixel (wr_row=IMG_H-1, wr_col=IMG_W-1):
  - Pixel is written, wr_row and wr_col return to 0, and the state moves to FULL.
  - frame_count increments.
  - If s_last=0 on that transfer, err_long pulses for one cycle; the frame is still accepted.
- State FULL:
  - s_ready=0, frame_valid=1.
  - img is held bit-stable; no writes occur.
  - frame_valid rises the cycle after the final transfer (latency 1).
- Leaving FULL: frame_ack=1 sampled in FULL gives FILL on the next edge. s_ready=1 and frame_valid=0 from that cycle, and the next frame may transfer in that same cycle.
- frame_ack in FILL is ignored.
- frame_ack held high across several cycles in FULL gives a single transition.
- s_valid in FULL is ignored (no transfer, since s_ready=0). The upstream must hold s_data stable until ready.
- err_short and err_long are registered and never asserted together. Each is high for exactly one cycle per event.
- Reset asserted mid-frame or in FULL: immediate return to reset values; the partial frame is abandoned.
- s_ready and frame_valid are registered outputs; there are no combinational paths from inputs to outputs.

Test Plan:
- Stream 0..783 (pixel = index mod 256), s_last on pixel 783, s_valid continuous:
  - frame_valid=1 the cycle after the last transfer
  - img[0]=0, img[27]=27, img[28]=28, img[783]=15
  - frame_count=1, no error pulses
- In FULL, drive s_valid=1 with s_data=0xAA for 50 cycles: s_ready=0 and img unchanged. Then pulse frame_ack: s_ready=1 next cycle, frame_valid=0, wr_row=wr_col=0.
- Assert s_last on pixel 100:
  - err_short pulses once; frame_valid stays 0; frame_count unchanged
  - a following full 784-pixel frame completes normally with img[0] equal to its first pixel.
- 784 pixels with s_last=0 throughout: err_long pulses once, frame_valid=1, frame_count increments.
- Randomised s_valid gaps (about 30% idle) across a full frame: final img identical to the gap-free case, and wr_col/wr_row advance only on transfers.
- Assert reset after 400 pixels: s_ready=1, wr_row=wr_col=0, frame_count=0 immediately (asynchronous). A subsequent full frame loads correctly.
